// File: rtl/z80_io_port_ctrl.sv
// Z80 I/O cycle sequencer: input synchronisation, port decode, register handshake and bus ownership.
// Optional WAIT generation during reads is built when IOWAIT_EN is defined; otherwise wait_n is tied high.
module z80_io_port_ctrl #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned ADDR_BITS   = 1,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           a,
  input  logic [7:0]           d_in,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 busdir,
  output logic                 wait_n,
  output logic [ADDR_BITS-1:0] reg_idx,
  output logic [7:0]           reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [7:0]           reg_rdata,
  input  logic                 reg_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StDecode   = 3'd1;
  localparam logic [2:0] StRdReq    = 3'd2;
  localparam logic [2:0] StRdDrive  = 3'd3;
  localparam logic [2:0] StTurn     = 3'd4;
  localparam logic [2:0] StWrStrobe = 3'd5;
  localparam logic [2:0] StWaitEnd  = 3'd6;

  logic [SYNC_STAGES-1:0] iorq_sync, rd_sync, wr_sync, m1_sync, vld_q;
  logic                   iorq_s, rd_s, wr_s, m1_s;
  logic                   armed_q, armed_d;
  logic                   hit;

  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [7:0]           d_out_q, d_out_d;
  logic                 d_oe_q, d_oe_d;
  logic                 busdir_q, busdir_d;
  logic [ADDR_BITS-1:0] reg_idx_q, reg_idx_d;
  logic [7:0]           reg_wdata_q, reg_wdata_d;
  logic                 reg_we_q, reg_we_d;
  logic                 reg_re_q, reg_re_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iorq_sync <= '1;
      rd_sync   <= '1;
      wr_sync   <= '1;
      m1_sync   <= '1;
      vld_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], iorq_n};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_n};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], wr_n};
      m1_sync   <= {m1_sync[SYNC_STAGES-2:0], m1_n};
      vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      armed_q   <= armed_d;
    end
  end

  assign iorq_s = iorq_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];
  assign m1_s   = m1_sync[SYNC_STAGES-1];

  // After reset, an IORQ already held low must be seen high once (with a full sync pipeline)
  // before any new cycle is accepted.
  assign armed_d = armed_q | ((&vld_q) & iorq_s);

  assign hit = (a[7:ADDR_BITS] == BASE_ADDR[7:ADDR_BITS]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    busdir_d    = busdir_q;
    reg_idx_d   = reg_idx_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        d_oe_d   = 1'b0;
        busdir_d = 1'b1;
        if (armed_q && !iorq_s) begin
          state_d = m1_s ? StDecode : StWaitEnd;
        end
      end
      StDecode: begin
        reg_idx_d = a[ADDR_BITS-1:0];
        if (iorq_s) begin
          state_d = StIdle;
        end else if (!hit) begin
          state_d = StWaitEnd;
        end else if (!rd_s) begin
          state_d  = StRdReq;
          reg_re_d = 1'b1;
          busdir_d = 1'b0;
          cnt_d    = '0;
        end else if (!wr_s) begin
          state_d = StWrStrobe;
        end
      end
      StRdReq: begin
        busdir_d = 1'b0;
        d_oe_d   = 1'b0;
        if (iorq_s) begin
          state_d = StTurn;
        end else if (reg_ack) begin
          d_out_d = reg_rdata;
          d_oe_d  = 1'b1;
          state_d = StRdDrive;
        end else if (cnt_q == TimeoutVal) begin
          d_out_d = 8'hFF;
          d_oe_d  = 1'b1;
          state_d = StRdDrive;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdDrive: begin
        d_oe_d   = 1'b1;
        busdir_d = 1'b0;
        if (iorq_s || rd_s) begin
          d_oe_d  = 1'b0;
          state_d = StTurn;
        end
      end
      // One guard cycle with busdir still low after d_oe has dropped.
      StTurn: begin
        d_oe_d   = 1'b0;
        busdir_d = 1'b1;
        state_d  = StIdle;
      end
      StWrStrobe: begin
        reg_wdata_d = d_in;
        reg_we_d    = 1'b1;
        state_d     = StWaitEnd;
      end
      StWaitEnd: begin
        if (iorq_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        d_oe_d   = 1'b0;
        busdir_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      busdir_q    <= 1'b1;
      reg_idx_q   <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      busdir_q    <= busdir_d;
      reg_idx_q   <= reg_idx_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
    end
  end

`ifdef IOWAIT_EN
  logic wait_q, wait_d;

  // Low while the read request is still outstanding after its first cycle.
  always_comb begin
    wait_d = 1'b1;
    if (state_q == StRdReq && !iorq_s && !reg_ack && cnt_q != TimeoutVal) begin
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= 1'b1;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_n = wait_q;
`else
  assign wait_n = 1'b1;
`endif

  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign busdir    = busdir_q;
  assign reg_idx   = reg_idx_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;

endmodule

// File: tb/tb_z80_io_port_ctrl.sv
// Randomised bench for z80_io_port_ctrl: bus cycles checked against a transaction-level model
// of decode, handshake outcome and bus ownership rules.
module tb_z80_io_port_ctrl;

  localparam logic [7:0] Base = 8'h00;
  localparam int         Ab   = 1;
  localparam int         To   = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, d_in, d_out, reg_wdata, reg_rdata;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic       d_oe, busdir, wait_n, reg_we, reg_re, reg_ack;
  logic [Ab-1:0] reg_idx;

  always #5 clk = ~clk;

  z80_io_port_ctrl #(
    .BASE_ADDR  (Base),
    .ADDR_BITS  (Ab),
    .TIMEOUT    (To),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .d_in     (d_in),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .m1_n     (m1_n),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .busdir   (busdir),
    .wait_n   (wait_n),
    .reg_idx  (reg_idx),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus-side settings read by the monitor/responder.
  int         ack_delay = 0;
  logic [7:0] rdata_val = 8'h00;
  logic [7:0] exp_dout  = 8'h00;

  // Cumulative observations; the stimulus takes deltas per transaction.
  int         re_tot = 0, we_tot = 0, both_tot = 0, doe_tot = 0, bd_low_tot = 0;
  int         wait_low_tot = 0, viol_tot = 0, dout_bad_tot = 0;
  logic [7:0] last_re_idx = 8'h00, last_we_idx = 8'h00, last_we_data = 8'h00;
  logic       prev_doe = 1'b0, prev_bd = 1'b1, exit_pend = 1'b0, resp_active = 1'b0;
  int         resp_t = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_doe    = 1'b0;
      prev_bd     = 1'b1;
      exit_pend   = 1'b0;
      resp_active = 1'b0;
      reg_ack     = 1'b0;
    end else begin
      if (reg_re) begin
        re_tot++;
        last_re_idx = 8'(reg_idx);
      end
      if (reg_we) begin
        we_tot++;
        last_we_idx  = 8'(reg_idx);
        last_we_data = reg_wdata;
      end
      if (reg_re && reg_we) both_tot++;
      if (!busdir) bd_low_tot++;
      if (!wait_n) wait_low_tot++;
      if (d_oe) begin
        doe_tot++;
        if (d_out !== exp_dout) dout_bad_tot++;
        if (busdir) viol_tot++;
        if (!prev_doe && prev_bd) viol_tot++;
      end
      if (exit_pend) begin
        if (!busdir) viol_tot++;
        exit_pend = 1'b0;
      end
      if (prev_doe && !d_oe) begin
        if (busdir) viol_tot++;
        exit_pend = 1'b1;
      end
      prev_doe = d_oe;
      prev_bd  = busdir;
      // Register-side responder: ack ack_delay cycles after reg_re (0 = same cycle).
      if (reg_re) begin
        resp_active = 1'b1;
        resp_t      = 0;
      end
      reg_rdata = rdata_val;
      if (resp_active) begin
        reg_ack = (resp_t == ack_delay);
        if (reg_ack) resp_active = 1'b0;
        resp_t++;
      end else begin
        reg_ack = 1'b0;
      end
    end
  end

  task automatic bus_idle();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_doe"}, 32'(d_oe), 32'd0);
    check({tag, "_busdir"}, 32'(busdir), 32'd1);
    check({tag, "_waitn"}, 32'(wait_n), 32'd1);
  endtask

  // kind: 0 read, 1 write, 2 interrupt acknowledge.
  task automatic do_cycle(input int kind, input logic [7:0] addr, input logic [7:0] data,
                          input int delay);
    int  s_re, s_we, s_both, s_doe, s_bd, s_wait, s_viol, s_bad;
    int  exp_wait;
    bit  hit, exp_re, exp_we;
    s_re = re_tot; s_we = we_tot; s_both = both_tot; s_doe = doe_tot;
    s_bd = bd_low_tot; s_wait = wait_low_tot; s_viol = viol_tot; s_bad = dout_bad_tot;
    hit    = ((int'(addr) >> Ab) == (int'(Base) >> Ab));
    exp_re = (kind == 0) && hit;
    exp_we = (kind == 1) && hit;
    ack_delay = delay;
    rdata_val = data;
    exp_dout  = (delay <= To) ? data : 8'hFF;
`ifdef IOWAIT_EN
    exp_wait = exp_re ? ((delay <= To) ? delay : To) : 0;
`else
    exp_wait = 0;
`endif
    @(negedge clk);
    a      = addr;
    d_in   = data;
    iorq_n = 1'b0;
    m1_n   = (kind == 2) ? 1'b0 : 1'b1;
    rd_n   = (kind == 0) ? 1'b0 : 1'b1;
    wr_n   = (kind == 1) ? 1'b0 : 1'b1;
    repeat (30) @(negedge clk);
    bus_idle();
    repeat (8) @(negedge clk);
    check("re_count", 32'(re_tot - s_re), 32'(exp_re));
    check("we_count", 32'(we_tot - s_we), 32'(exp_we));
    check("both_strobes", 32'(both_tot - s_both), 32'd0);
    check("busdir_rules", 32'(viol_tot - s_viol), 32'd0);
    check("wait_low_cycles", 32'(wait_low_tot - s_wait), 32'(exp_wait));
    if (exp_re) begin
      check("rd_idx", 32'(last_re_idx), 32'(int'(addr) % (1 << Ab)));
      check("rd_doe_seen", 32'(doe_tot > s_doe), 32'd1);
      check("rd_dout", 32'(dout_bad_tot - s_bad), 32'd0);
      check("rd_busdir_low", 32'(bd_low_tot > s_bd), 32'd1);
    end else begin
      check("no_doe", 32'(doe_tot - s_doe), 32'd0);
      check("no_busdir_low", 32'(bd_low_tot - s_bd), 32'd0);
    end
    if (exp_we) begin
      check("wr_idx", 32'(last_we_idx), 32'(int'(addr) % (1 << Ab)));
      check("wr_data", 32'(last_we_data), 32'(data));
    end
    check_idle_outputs("end");
  endtask

  initial begin
    int s_re, s_doe, s_viol, s_bd;
    int kind, dly;
    logic [7:0] addr;
    rst_n = 1'b0;
    a = 8'h00; d_in = 8'h00;
    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(d_out), 32'h00);
    check("rst_idx", 32'(reg_idx), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'h00);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_re", 32'(reg_re), 32'd0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed cases.
    do_cycle(0, 8'h01, 8'hA5, 2);
    do_cycle(1, 8'h00, 8'h3C, 0);
    do_cycle(0, 8'h01, 8'h77, 255);
    do_cycle(0, 8'h7E, 8'h11, 0);
    do_cycle(2, 8'h01, 8'h22, 0);
    do_cycle(0, 8'h00, 8'h5C, 0);
    do_cycle(0, 8'h01, 8'hC3, 15);
    do_cycle(0, 8'h00, 8'h96, 16);

    // Aborted read with a late acknowledge.
    s_re = re_tot; s_doe = doe_tot; s_viol = viol_tot; s_bd = bd_low_tot;
    ack_delay = 8;
    rdata_val = 8'hEE;
    @(negedge clk);
    a = 8'h01; iorq_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 20 && re_tot == s_re; i++) @(negedge clk);
    check("abort_re_seen", 32'(re_tot - s_re), 32'd1);
    repeat (3) @(negedge clk);
    bus_idle();
    repeat (15) @(negedge clk);
    check("abort_no_doe", 32'(doe_tot - s_doe), 32'd0);
    check("abort_busdir_low", 32'(bd_low_tot > s_bd), 32'd1);
    check("abort_rules", 32'(viol_tot - s_viol), 32'd0);
    check_idle_outputs("abort");
    do_cycle(0, 8'h01, 8'h3A, 3);

    // Reset while driving read data; the held IORQ must not start a new cycle.
    ack_delay = 1;
    rdata_val = 8'h5A;
    exp_dout  = 8'h5A;
    @(negedge clk);
    a = 8'h01; iorq_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 30 && !d_oe; i++) @(negedge clk);
    check("pre_rst_doe", 32'(d_oe), 32'd1);
    check("pre_rst_dout", 32'(d_out), 32'h5A);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    check("mid_rst_re", 32'(reg_re), 32'd0);
    rst_n = 1'b1;
    s_re = re_tot; s_doe = doe_tot;
    repeat (10) @(negedge clk);
    check("held_iorq_no_re", 32'(re_tot - s_re), 32'd0);
    check("held_iorq_no_doe", 32'(doe_tot - s_doe), 32'd0);
    bus_idle();
    repeat (8) @(negedge clk);
    do_cycle(0, 8'h01, 8'hB4, 2);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3) kind = 0;
      addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      dly  = int'($urandom_range(0, 20));
      do_cycle(kind, addr, 8'($urandom_range(0, 255)), dly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/z80_io_port_ctrl.md
Name: z80_io_port_ctrl

Overview:
Sequencer for Z80 I/O cycles on the CPLD bus. It synchronises IORQ/RD/WR/M1 to the local clock and decodes a block of port addresses. It runs a request/acknowledge handshake with internal register logic, such as the free-running counter byte sources. It owns the data-bus output enable and the external transceiver direction (busdir), with one-cycle turnaround guards, so no internal block drives the Z80 bus directly.

Parameters:
BASE_ADDR, 8'h00, base I/O port; the decoded window is BASE_ADDR .. BASE_ADDR+2**ADDR_BITS-1.
ADDR_BITS, 1, number of low address bits passed out as the register index (1..4).
TIMEOUT, 15, maximum clk cycles to wait for reg_ack on a read (1..255).
SYNC_STAGES, 2, flip-flop stages on iorq_n/rd_n/wr_n/m1_n (2..3).

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous reset, active-low.
a  in  8  Z80 address bus, low byte.
d_in  in  8  Z80 data bus as seen from the transceiver (write data).
iorq_n  in  1  Z80 IORQ, async.
rd_n  in  1  Z80 RD, async.
wr_n  in  1  Z80 WR, async.
m1_n  in  1  Z80 M1, async; IORQ and M1 together mean interrupt acknowledge.
d_out  out  8  read data to the bus.
d_oe  out  1  1 = drive d_out onto the bus.
busdir  out  1  transceiver direction; 1 = bus to CPLD (idle), 0 = CPLD drives the bus.
wait_n  out  1  Z80 WAIT request, active-low.
reg_idx  out  ADDR_BITS  register index = a[ADDR_BITS-1:0] latched in DECODE.
reg_wdata  out  8  latched write data.
reg_we  out  1  one-cycle write strobe.
reg_re  out  1  one-cycle read request.
reg_rdata  in  8  read data, valid when reg_ack=1.
reg_ack  in  1  read acknowledge; may assert in the same cycle as reg_re.

Behaviour:
- Reset values: d_out=8'h00, d_oe=0, busdir=1, wait_n=1, reg_idx=0, reg_wdata=0, reg_we=0, reg_re=0. State is IDLE and the timeout counter is 0.
- Reset asserted mid-cycle: the block returns to IDLE on that edge, d_oe=0 and busdir=1 immediately. No strobe is issued.
- Sync: iorq_n, rd_n, wr_n and m1_n each pass through SYNC_STAGES flops (reset value 1). `a` and d_in are sampled only in DECODE/WR_STROBE, where they are stable.
- hit = (a[7:ADDR_BITS] == BASE_ADDR[7:ADDR_BITS]).
- IDLE: if synced iorq_n=0 and m1_n=1, go to DECODE. If iorq_n=0 and m1_n=0 (INTA), go to WAIT_END with the bus untouched.
- DECODE:
  - latch reg_idx.
  - synced iorq_n=1: go to IDLE.
  - !hit: go to WAIT_END.
  - hit and rd_n=0: go to RD_REQ, pulse reg_re for 1 cycle, set busdir=0.
  - hit and wr_n=0: go to WR_STROBE.
  - otherwise: stay in DECODE.
- RD_REQ:
  - busdir=0, d_oe=0; the counter increments each cycle.
  - reg_ack=1: d_out<=reg_rdata, go to RD_DRIVE.
  - counter==TIMEOUT: d_out<=8'hFF, go to RD_DRIVE.
  - synced iorq_n=1 first (aborted cycle): go to TURN; a late ack is ignored.
- RD_DRIVE: d_oe=1, busdir=0. d_out is held until synced iorq_n=1 or rd_n=1, then go to TURN.
- TURN: d_oe=0, busdir=0 for one guard cycle, then IDLE with busdir=1. busdir therefore leads d_oe by ≥1 cycle on entry and trails it by 1 cycle on exit.
- WR_STROBE: reg_wdata<=d_in, reg_we=1 for exactly 1 cycle, then WAIT_END. Writes take no ack.
- WAIT_END: stay until synced iorq_n=1, then IDLE. This guarantees one transaction per IORQ assertion.
- Counter clears on every entry to RD_REQ; width is clog2(TIMEOUT+1).
- reg_we and reg_re are never both 1. At most one strobe per bus cycle.

Optional Feature:
Macro IOWAIT_EN.
- Defined: wait_n=0 from the cycle after reg_re until the cycle reg_ack or timeout is seen, then 1. It is forced to 1 on abort or reset.
- Undefined: wait_n is tied to 1 and no WAIT logic is built; the port remains.

Test Plan:
- Read port 8'h01 with BASE_ADDR=0 and reg_ack returned 2 cycles after reg_re with reg_rdata=8'hA5 -> reg_idx=1, one reg_re pulse, d_out=8'hA5, d_oe=1 until iorq_n rises, busdir low 1 cycle before d_oe and 1 cycle after it.
- Write 8'h3C to port 8'h00 -> exactly one reg_we pulse with reg_wdata=8'h3C and reg_idx=0; d_oe and busdir stay 0/1 throughout.
- Read port 8'h01 with reg_ack never asserted, TIMEOUT=15 -> d_out=8'hFF driven at RD_REQ cycle 15; with IOWAIT_EN, wait_n is low for those cycles.
- Access port 8'h7E (miss) and an INTA cycle (iorq_n=0, m1_n=0) -> no strobes, d_oe=0, busdir=1, return to IDLE after iorq_n rises.
- Read aborted (iorq_n rises while in RD_REQ) followed by a late reg_ack -> TURN then IDLE; d_oe never 1; the next read proceeds normally.
- rst_n=0 during RD_DRIVE -> next edge d_oe=0, busdir=1, wait_n=1, state IDLE; an iorq_n still held low is not reprocessed until it goes high and low again.
